// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the Gray counter control stage: FSM encoding,
// counter width helper and default timing constants.
package clk_en_gen_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // 50 MHz board clock: 10 Hz run rate, 5 ms debounce window
    localparam int DIV_BOARD        = 5_000_000;
    localparam int DEB_CYCLES_BOARD = 250_000;
    localparam int DIV_SIM          = 10;
    localparam int DEB_CYCLES_SIM   = 4;

    // Width needed to count 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_gen_btn_debounce.sv
// Button conditioning: two-flop synchronizer, debounce counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
    import clk_en_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    // A level is accepted only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            stable_prev <= stable;
            if (sync2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = stable & ~stable_prev;

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator for the Gray counter: run/pause FSM, RUN-rate
// prescaler and registered clk_en / running outputs.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int DIV        = DIV_SIM,
    parameter int DEB_CYCLES = DEB_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic run_btn,
    input  logic step_btn,
    output logic clk_en,
    output logic running
);

    localparam int            PW = cnt_width(DIV);
    localparam logic [PW-1:0] TC = PW'(DIV - 1);

    logic          run_press;
    logic          step_press;
    state_t        state;
    state_t        state_d;
    logic [PW-1:0] count;
    logic [PW-1:0] count_d;
    logic          clk_en_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (run_btn),
        .press   (run_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (step_btn),
        .press   (step_press)
    );

    // run_press outranks step_press; a terminal count on the stop edge still fires
    always_comb begin
        state_d  = state;
        count_d  = '0;
        clk_en_d = 1'b0;
        case (state)
            PAUSE: begin
                clk_en_d = step_press & ~run_press;
                if (run_press) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                clk_en_d = (count == TC);
                if (run_press) begin
                    state_d = PAUSE;
                end else if (count != TC) begin
                    count_d = count + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PAUSE;
            count   <= '0;
            clk_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            clk_en  <= clk_en_d;
            running <= (state_d == RUN);
        end
    end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Upstream control stage for the 4-bit Gray counter system on the lab board.
- Turns the fast board clock plus two raw push-buttons (run/pause, single-step) into a single-cycle clock-enable pulse, clk_en, that advances the Gray counter.
- Provides a free-running divided rate in RUN and one manual step per button press in PAUSE.
- Also drives a "running" status LED.

Parameters:
- DIV, 10: clk cycles per clk_en pulse in RUN; legal range ≥1.
- DEB_CYCLES, 4: consecutive stable synchronized samples needed to accept a button level change; legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- run_btn  input  1  raw, asynchronous, bouncy run/pause button; active-high.
- step_btn  input  1  raw, asynchronous, bouncy single-step button; active-high.
- clk_en  output  1  registered one-cycle enable pulse to the Gray counter.
- running  output  1  registered; 1 in RUN, 0 in PAUSE.

Behaviour:
- Reset (rst low, asynchronous): all flops clear.
  - clk_en=0, running=0, FSM=PAUSE.
  - Prescaler count=0; synchronizers, debounced levels and debounce counters all 0.
  - Release is synchronous in effect: the first active edge after rst rises behaves as a normal cycle.
- Per-button path (identical for both buttons):
  - Synchronizer: two flops.
  - Debounce:
    - If sync ≠ stable: cnt increments.
    - When sync ≠ stable and cnt==DEB_CYCLES-1: stable takes sync's value and cnt returns to 0.
    - If sync == stable: cnt returns to 0.
  - Press pulse = stable & ~stable_prev. Active for exactly one cycle per accepted rising level; release generates nothing.
  - Timing: raw high sampled at edge 1 → stable rises at edge 2+DEB_CYCLES → FSM and outputs react at edge 3+DEB_CYCLES.
  - Any glitch shorter than DEB_CYCLES synchronized cycles produces no pulse.
- FSM states: PAUSE, RUN.
  - PAUSE → RUN on run_press; prescaler count forced to 0.
  - RUN → PAUSE on run_press; prescaler count forced to 0.
  - step_press is ignored in RUN.
  - If run_press and step_press coincide, run_press wins and step_press is dropped.
- Prescaler (RUN only):
  - count runs 0..DIV-1 and wraps to 0.
  - Held at 0 in PAUSE.
- clk_en is registered. It is set for the next cycle when either:
  - current state is RUN and count==DIV-1, or
  - current state is PAUSE and step_press is high and run_press is low.
- Resulting clk_en timing:
  - First pulse comes exactly DIV cycles after running rises.
  - Then one pulse every DIV cycles, each 1 cycle wide.
  - DIV=1 gives clk_en high every cycle in RUN, starting 1 cycle after running rises.
- Terminal count in the same cycle as run_press (RUN → PAUSE): that pulse is still issued; no further pulses follow.
- running = registered copy of (FSM == RUN); changes on the same edge as the state.
- Holding a button down indefinitely yields exactly one press.
- Reset asserted mid-RUN: outputs drop immediately without waiting for clk; after release the block stays in PAUSE until a new run_press.

Decomposition:
- Shared package/include:
  - State encoding: PAUSE=1'b0, RUN=1'b1.
  - clog2-style width function used for the prescaler and debounce counter widths.
  - Default DIV and DEB_CYCLES constants for the lab board and for simulation.
- Sub-module btn_debounce:
  - Contains the synchronizer, debounce counter, stable level and rising-edge pulse.
  - Parameter DEB_CYCLES; ports clk, rst, btn_raw, press.
  - Instantiated twice.
- Top level: FSM, prescaler and output registers.

Test Plan (DIV=10, DEB_CYCLES=4, clk period 10 ns):
- Reset: hold rst low 3 cycles, buttons idle, then run 100 cycles → clk_en=0 and running=0 throughout; no pulse ever.
- Clean run press: run_btn high 20 cycles starting before edge 1 → running rises at edge 7; clk_en first high 10 cycles after running rises, then every 10 cycles, each 1 cycle wide; release of the button causes no change.
- Bounce rejection: run_btn toggled as 3-cycle high / 2-cycle low bursts for 40 cycles, then low → running stays 0, clk_en stays 0.
- Single step: in PAUSE, step_btn held high 50 cycles → exactly one clk_en pulse, at edge 7; a second press after release → exactly one more pulse.
- Step ignored in RUN, stop and restart:
  - In RUN, press step → pulse period stays 10 with no extra pulse.
  - Press run again → running=0 and no clk_en afterwards.
  - Press run a third time → first clk_en 10 cycles after running rises (prescaler restarted).
- Async reset mid-RUN: drive rst low 3 ns after an edge → clk_en=0 and running=0 before the next edge; after release, 50 idle cycles → no clk_en, running=0.
